sqrt_seq: RTL and testbench
===========================

# sqrt_seq

Sequential integer square root unit that sits directly upstream of the circular-motion handler. It accepts an unsigned radicand on a trigger/rdy/done handshake and produces the floor square root and the remainder. It computes two radicand bits per enabled cycle using the restoring bit-pair method. The circular handler triggers it once per arc, uses the result to size its step loop, and waits on `done` before driving the motors.

## Interface
Parameters:
- DATA_WIDTH, 32, radicand width; must be even and ≥ 4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- clk_en  in  1  module enable; all state and registers hold when low.
- trigger  in  1  start request, sampled in IDLE.
- radicand  in  DATA_WIDTH  unsigned operand, sampled on trigger acceptance.
- root  out  DATA_WIDTH/2  floor(sqrt(radicand)), registered.
- remainder  out  DATA_WIDTH/2+1  radicand − root², registered.
- done  out  1  result valid / unit idle.
- rdy  out  1  ready to accept trigger.

## Operation
- States are IDLE, CALC and DONE. The outputs `rdy` and `done` are Moore outputs decoded from the state:
  - IDLE: rdy=1, done=1.
  - CALC: rdy=0, done=0.
  - DONE: rdy=0, done=1.
- IDLE → CALC on `trigger & clk_en`:
  - Load radicand into the shift register `op`.
  - Clear the working `rem` and `rt`.
  - Load the iteration counter with DATA_WIDTH/2.
- CALC performs one iteration per enabled cycle:
  - s = {rem, op[MSB:MSB-1]}
  - t = {rt, 2'b01}
  - If s ≥ t: rem ← s − t and rt ← {rt,1}.
  - Otherwise: rem ← s and rt ← {rt,0}.
  - op ← op << 2, and the counter decrements.
- `rem` is DATA_WIDTH/2+2 bits wide internally. The comparison and subtraction are unsigned at that width. The value never exceeds 2·rt, so it fits in DATA_WIDTH/2+1 bits on the output.
- CALC → DONE when the counter reaches 1 on an enabled edge. On that edge the last iteration is applied and `root` and `remainder` are updated from the final `rt` and `rem`.
- DONE → IDLE unconditionally on the next enabled edge.
- `root` and `remainder` change only on the final CALC edge. They stay stable through DONE, IDLE and the whole next computation until its final edge.
- A trigger in CALC or DONE is ignored; no queuing.
- If trigger is still high in IDLE, a new computation starts. The consumer deasserts trigger once rdy falls.
- Radicand is sampled only at acceptance; later changes have no effect.

## Timing
- Reset values: state IDLE, rdy=1, done=1, root=0, remainder=0, counter=0.
- Reset mid-CALC or mid-DONE aborts to IDLE and clears root and remainder on the same edge. Reset has priority over clk_en.
- Latency is counted in enabled edges. The acceptance edge is E0.
  - rdy and done fall after E0.
  - Iterations occur on E1..E(DATA_WIDTH/2).
  - done rises after E(DATA_WIDTH/2), with a valid result at the same time.
  - rdy rises after E(DATA_WIDTH/2+1).
  - For DATA_WIDTH=32: result after 16 enabled edges from acceptance, and rdy again after 17.
- Disabled cycles (clk_en=0) insert stalls only; the result is identical.
- Throughput is one result per DATA_WIDTH/2+2 enabled cycles when trigger is held.

## Structure
- The shared processor package holds:
  - the `SqrtSeq_state` enum (IDLE, CALC, DONE);
  - the constant `SQRT_DEFAULT_WIDTH = 32`.
- One sub-module: `sqrt_seq_fsm`. It takes clk, reset, clk_en, trigger and last_iter, and produces load, step, latch_result, rdy and done.
- The datapath (op, rem, rt, counter and output registers) lives in `sqrt_seq`.

## Test plan
- radicand=0, 1, 15, 16, each triggered from IDLE → root/remainder of 0/0, 1/0, 3/6 and 4/0 respectively. done rises exactly 16 enabled edges after acceptance, and rdy rises at 17.
- radicand=0xFFFFFFFF → root=0xFFFF, remainder=0x1FFFE. radicand=0xFFFE0001 → root=0xFFFF, remainder=0.
- clk_en toggled 1-0-1-0 throughout a run with radicand=1000 → root=31, remainder=39. Latency is 32 clk cycles to done, and outputs are frozen during disabled cycles.
- Pulse trigger with a different radicand at CALC edge 5 and in DONE → ignored, and the first result is unchanged. Holding trigger high through IDLE re-triggers immediately after DONE.
- Assert reset at CALC edge 8 → next cycle IDLE, rdy=1, done=1, root=0, remainder=0. A new trigger with radicand=144 → root=12, remainder=0.
- Randomized 1000 radicands checked against the reference model: root² ≤ radicand < (root+1)², and remainder = radicand − root².

Source files
------------

// File: rtl/sqrt_seq_pkg.sv
// Shared definitions for the sequential square-root unit feeding the circular-motion handler.
package sqrt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } SqrtSeq_state;

  localparam int SQRT_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/sqrt_seq_fsm.sv
// Control FSM for sqrt_seq: sequences load / iterate / latch and owns the rdy/done handshake.
module sqrt_seq_fsm
  import sqrt_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic trigger,
  input  logic last_iter,
  output logic load,
  output logic step,
  output logic latch_result,
  output logic rdy,
  output logic done
);

  SqrtSeq_state r_state;
  logic         r_rdy;
  logic         r_done;

  // State register with rdy/done registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rdy   <= 1'b1;
      r_done  <= 1'b1;
    end else if (clk_en) begin
      case (r_state)
        IDLE: begin
          if (trigger) begin
            r_state <= CALC;
            r_rdy   <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        CALC: begin
          if (last_iter) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_rdy   <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_rdy   <= 1'b1;
          r_done  <= 1'b1;
        end
      endcase
    end
  end

  assign load         = clk_en & (r_state == IDLE) & trigger;
  assign step         = clk_en & (r_state == CALC);
  assign latch_result = clk_en & (r_state == CALC) & last_iter;
  assign rdy          = r_rdy;
  assign done         = r_done;

endmodule

// File: rtl/sqrt_seq.sv
// Sequential integer square root, two radicand bits per enabled cycle (restoring bit-pair method).
module sqrt_seq
  import sqrt_seq_pkg::*;
#(
  parameter int DATA_WIDTH = SQRT_DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    trigger,
  input  logic [DATA_WIDTH-1:0]   radicand,
  output logic [DATA_WIDTH/2-1:0] root,
  output logic [DATA_WIDTH/2:0]   remainder,
  output logic                    done,
  output logic                    rdy
);

  localparam int HW = DATA_WIDTH / 2;
  localparam int CW = $clog2(HW + 1);

  logic [DATA_WIDTH-1:0] r_op;
  logic [HW+1:0]         r_rem;
  logic [HW-1:0]         r_rt;
  logic [CW-1:0]         r_cnt;
  logic [HW-1:0]         r_root;
  logic [HW:0]           r_remainder;

  logic          w_load;
  logic          w_step;
  logic          w_latch;
  logic          w_last_iter;
  logic [HW+1:0] w_s;
  logic [HW+1:0] w_t;
  logic          w_ge;
  logic [HW+1:0] w_rem_nxt;
  logic [HW-1:0] w_rt_nxt;
  logic          w_unused;

  sqrt_seq_fsm u_fsm (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .trigger      (trigger),
    .last_iter    (w_last_iter),
    .load         (w_load),
    .step         (w_step),
    .latch_result (w_latch),
    .rdy          (rdy),
    .done         (done)
  );

  // rem never exceeds 2*rt, so its top bits drop out of the shifted partial remainder.
  assign w_s         = {r_rem[HW-1:0], r_op[DATA_WIDTH-1 -: 2]};
  assign w_t         = {r_rt, 2'b01};
  assign w_ge        = (w_s >= w_t);
  assign w_rem_nxt   = w_ge ? (w_s - w_t) : w_s;
  assign w_rt_nxt    = {r_rt[HW-2:0], w_ge};
  assign w_last_iter = (r_cnt == CW'(1));
  assign w_unused    = ^r_rem[HW+1:HW];

  // Datapath: operand load, one bit-pair iteration per step, result latch on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op        <= '0;
      r_rem       <= '0;
      r_rt        <= '0;
      r_cnt       <= '0;
      r_root      <= '0;
      r_remainder <= '0;
    end else if (w_load) begin
      r_op  <= radicand;
      r_rem <= '0;
      r_rt  <= '0;
      r_cnt <= CW'(HW);
    end else if (w_step) begin
      r_op  <= {r_op[DATA_WIDTH-3:0], 2'b00};
      r_rem <= w_rem_nxt;
      r_rt  <= w_rt_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_latch) begin
        r_root      <= w_rt_nxt;
        r_remainder <= w_rem_nxt[HW:0];
      end
    end
  end

  assign root      = r_root;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_sqrt_seq.sv
// Directed and reference-model checks for sqrt_seq at DATA_WIDTH=32.
module tb_sqrt_seq;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        trigger;
  logic [31:0] radicand;
  logic [15:0] root;
  logic [16:0] remainder;
  logic        done;
  logic        rdy;

  int n_cmp;
  int n_err;
  logic [15:0] last_root;

  sqrt_seq #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .trigger   (trigger),
    .radicand  (radicand),
    .root      (root),
    .remainder (remainder),
    .done      (done),
    .rdy       (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps until done rises, bounded; cyc reports how many clocks it took.
  task automatic wait_done(input bit toggle, output int cyc, output bit frz);
    cyc = 0;
    frz = 1'b1;
    while (!done && cyc < 200) begin
      clk_en = toggle ? ~clk_en : 1'b1;
      tick();
      cyc++;
      if (!done && root !== last_root) frz = 1'b0;
    end
  endtask

  task automatic do_run(input string tag, input logic [31:0] rad, input logic [15:0] er,
                        input logic [16:0] erem, input int exp_lat, input bit toggle);
    int cyc;
    bit frz;
    clk_en   = 1'b1;
    trigger  = 1'b1;
    radicand = rad;
    tick();
    trigger  = 1'b0;
    radicand = ~rad;
    chk({tag, "_busy"}, {62'd0, rdy, done}, 64'd0);
    wait_done(toggle, cyc, frz);
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_root"}, 64'(root), 64'(er));
    chk({tag, "_rem"}, 64'(remainder), 64'(erem));
    chk({tag, "_frozen"}, 64'(frz), 64'd1);
    clk_en = 1'b1;
    tick();
    chk({tag, "_rdy"}, {62'd0, rdy, done}, 64'd3);
    last_root = er;
  endtask

  initial begin
    int cyc;
    bit frz;
    longint x, r;
    n_cmp = 0;
    n_err = 0;
    last_root = 16'd0;
    reset = 1'b1;
    clk_en = 1'b1;
    trigger = 1'b0;
    radicand = 32'd0;
    tick();
    tick();
    chk("rst_hs", {62'd0, rdy, done}, 64'd3);
    chk("rst_root", 64'(root), 64'd0);
    chk("rst_rem", 64'(remainder), 64'd0);
    reset = 1'b0;
    tick();

    do_run("r0",   32'd0,          16'd0,      17'd0,       16, 1'b0);
    do_run("r1",   32'd1,          16'd1,      17'd0,       16, 1'b0);
    do_run("r15",  32'd15,         16'd3,      17'd6,       16, 1'b0);
    do_run("r16",  32'd16,         16'd4,      17'd0,       16, 1'b0);
    do_run("rmax", 32'hFFFF_FFFF,  16'hFFFF,   17'h1_FFFE,  16, 1'b0);
    do_run("rsq",  32'hFFFE_0001,  16'hFFFF,   17'd0,       16, 1'b0);
    do_run("ren",  32'd1000,       16'd31,     17'd39,      32, 1'b1);

    // Triggers in CALC and DONE are ignored; trigger still high in IDLE re-arms at once.
    trigger = 1'b1;
    radicand = 32'd100;
    tick();
    trigger = 1'b0;
    radicand = 32'd0;
    for (int i = 0; i < 4; i++) tick();
    trigger = 1'b1;
    radicand = 32'd49;
    tick();
    trigger = 1'b0;
    wait_done(1'b0, cyc, frz);
    chk("ign_lat", 64'(cyc + 5), 64'd16);
    chk("ign_root", 64'(root), 64'd10);
    chk("ign_rem", 64'(remainder), 64'd0);
    trigger = 1'b1;
    radicand = 32'd49;
    tick();
    chk("ign_done_idle", {62'd0, rdy, done}, 64'd3);
    tick();
    trigger = 1'b0;
    chk("retrig_busy", {62'd0, rdy, done}, 64'd0);
    chk("retrig_hold", 64'(root), 64'd10);
    last_root = 16'd10;
    wait_done(1'b0, cyc, frz);
    chk("retrig_lat", 64'(cyc), 64'd16);
    chk("retrig_root", 64'(root), 64'd7);
    chk("retrig_rem", 64'(remainder), 64'd0);
    tick();

    // Reset in the middle of a computation.
    trigger = 1'b1;
    radicand = 32'd500;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_hs", {62'd0, rdy, done}, 64'd3);
    chk("mrst_root", 64'(root), 64'd0);
    chk("mrst_rem", 64'(remainder), 64'd0);
    last_root = 16'd0;
    do_run("r144", 32'd144, 16'd12, 17'd0, 16, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      x = longint'($urandom());
      r = longint'($floor($sqrt(real'(x))));
      while ((r + 1) * (r + 1) <= x) r++;
      while (r * r > x) r--;
      do_run("rnd", 32'(x), 16'(r), 17'(x - r * r), 16, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
